sar_conv_ctrl: RTL and testbench

Conversion sequencer for the 8-bit SAR ADC. It drives sample/reset/enable to `sar_logic` and the sampling switch, and times the N_BITS bit-decision cycles. It captures the `sar_logic` D word into a single-entry result register and presents it to the digital host over a valid/ready handshake. It supports single-shot and continuous conversion, abort, and sticky overrun detection.

---
 rtl/sar_conv_ctrl.sv | 151 +++++++++++++++
 tb/tb_sar_conv_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_conv_ctrl.sv
// sar_conv_ctrl
// Conversion sequencer for the SAR ADC. Drives the sampling switch and the
// sample/reset/enable controls of sar_logic, times the bit-decision cycles,
// captures the sar_logic D word into a single-entry result register and
// hands it to the host over a valid/ready handshake.
//
// Ports:
//   clk        conversion clock, shared with sar_logic
//   rst        asynchronous reset, active low
//   start      level; accepted on a rising edge while idle
//   cont       continuous mode, sampled in CAPTURE only
//   abort      return to idle on the next edge, no capture
//   sar_d      result bus from sar_logic
//   res_ready  host accepts the result while res_valid is high
//   clr_ovr    synchronous clear of the overrun flag
//   sample     sampling switch control (1 = track)
//   sar_rst    active-high reset to sar_logic
//   sar_en     enable to sar_logic
//   busy       high whenever the sequencer is not idle
//   res_data   captured conversion result
//   res_valid  res_data holds an unconsumed result
//   overrun    sticky: a result was overwritten before being consumed
module sar_conv_ctrl #(
    parameter int N_BITS        = 8,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic [N_BITS-1:0] sar_d,
    input  logic              res_ready,
    input  logic              clr_ovr,
    output logic              sample,
    output logic              sar_rst,
    output logic              sar_en,
    output logic              busy,
    output logic [N_BITS-1:0] res_data,
    output logic              res_valid,
    output logic              overrun
);

    localparam int MAXC = (N_BITS > SAMPLE_CYCLES) ? N_BITS : SAMPLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] SMP_LAST  = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(N_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAMPLE,
        S_CONV,
        S_CAPTURE
    } state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          cap;
    logic          xfer;

    assign xfer = res_valid && res_ready;

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        cap     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt     = S_SAMPLE;
                    cnt_nxt = '0;
                end
            end
            S_SAMPLE: begin
                if (cnt == SMP_LAST) begin
                    nxt     = S_CONV;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_CONV: begin
                if (cnt == CONV_LAST) begin
                    nxt     = S_CAPTURE;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_CAPTURE: begin
                cap     = 1'b1;
                cnt_nxt = '0;
                nxt     = cont ? S_SAMPLE : S_IDLE;
            end
            default: begin
                nxt     = S_IDLE;
                cnt_nxt = '0;
            end
        endcase
        // abort overrides every transition and suppresses a pending capture
        if (abort) begin
            nxt     = S_IDLE;
            cnt_nxt = '0;
            cap     = 1'b0;
        end
    end

    // Outputs are decoded from the next state and registered, so they
    // line up with the state register without any input-to-output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sample    <= 1'b0;
            sar_rst   <= 1'b1;
            sar_en    <= 1'b0;
            busy      <= 1'b0;
            res_data  <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            sample  <= (nxt == S_SAMPLE);
            sar_rst <= (nxt == S_IDLE) || (nxt == S_SAMPLE);
            sar_en  <= (nxt == S_CONV);
            busy    <= (nxt != S_IDLE);

            if (cap) begin
                res_data  <= sar_d;
                res_valid <= 1'b1;
                // overwrite of an unconsumed result sets overrun; this
                // takes precedence over a coincident clear
                if (res_valid && !res_ready) begin
                    overrun <= 1'b1;
                end else if (clr_ovr) begin
                    overrun <= 1'b0;
                end
            end else begin
                if (xfer) begin
                    res_valid <= 1'b0;
                end
                if (clr_ovr) begin
                    overrun <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Testbench for sar_conv_ctrl: directed scenarios followed by random
// stimulus, checked against a timing-based reference model and a result
// scoreboard.
module tb_sar_conv_ctrl;

    localparam int S = 2;
    localparam int N = 8;
    localparam int L = S + N;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cont;
    logic       abort;
    logic [7:0] sar_d;
    logic       res_ready;
    logic       clr_ovr;
    logic       sample;
    logic       sar_rst;
    logic       sar_en;
    logic       busy;
    logic [7:0] res_data;
    logic       res_valid;
    logic       overrun;

    sar_conv_ctrl #(.N_BITS(N), .SAMPLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .abort     (abort),
        .sar_d     (sar_d),
        .res_ready (res_ready),
        .clr_ovr   (clr_ovr),
        .sample    (sample),
        .sar_rst   (sar_rst),
        .sar_en    (sar_en),
        .busy      (busy),
        .res_data  (res_data),
        .res_valid (res_valid),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: a conversion is "active" for L+1 cycles after the
    // accepting edge; m_k counts edges since that accept.
    bit         m_act;
    int         m_k;
    bit         m_pend;
    logic [7:0] m_pd;
    bit         m_ovr;
    logic [7:0] exp_q[$];

    task automatic model_reset();
        m_act  = 0;
        m_k    = 0;
        m_pend = 0;
        m_pd   = 8'h00;
        m_ovr  = 0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit xfer;
        bit cap;
        xfer = m_pend && res_ready;
        cap  = m_act && (m_k == L) && !abort;
        if (abort) begin
            m_act = 0;
            m_k   = 0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1;
                m_k   = 0;
            end
        end else if (m_k == L) begin
            if (cont) m_k = 0;
            else      m_act = 0;
        end else begin
            m_k = m_k + 1;
        end
        if (cap) begin
            if (m_pend && !xfer) begin
                m_ovr = 1;
                if (exp_q.size() > 0) exp_q[exp_q.size()-1] = sar_d;
                else                  exp_q.push_back(sar_d);
            end else begin
                if (clr_ovr) m_ovr = 0;
                exp_q.push_back(sar_d);
            end
            m_pd   = sar_d;
            m_pend = 1;
        end else begin
            if (xfer)    m_pend = 0;
            if (clr_ovr) m_ovr  = 0;
        end
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [7:0] e;
        cmp("sample",    8'(sample),    8'(m_act && m_k < S));
        cmp("sar_en",    8'(sar_en),    8'(m_act && m_k >= S && m_k < L));
        cmp("sar_rst",   8'(sar_rst),   8'(!m_act || m_k < S));
        cmp("busy",      8'(busy),      8'(m_act));
        cmp("res_valid", 8'(res_valid), 8'(m_pend));
        cmp("res_data",  res_data,      m_pd);
        cmp("overrun",   8'(overrun),   8'(m_ovr));
        // scoreboard: a transfer happens on the coming edge
        if (clk == 1'b0 && rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_empty: got %0h expected no result at %0t", res_data, $time);
            end else begin
                e = exp_q.pop_front();
                cmp("sb_data", res_data, e);
            end
        end
    endtask

    // Single process owns the model, the scoreboard and the counters.
    initial begin
        forever begin
            @(posedge clk or negedge clk or negedge rst);
            if (!rst) begin
                model_reset();
                #1 check_all();
            end else if (clk) begin
                model_edge();
            end else begin
                #1 check_all();
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
        sar_d = 8'h00; res_ready = 1'b0; clr_ovr = 1'b0;
        #22 rst = 1'b1;
        tick(1);

        // single shot
        sar_d = 8'hA5;
        pulse_start();
        tick(14);
        res_ready = 1'b1; tick(1); res_ready = 1'b0; tick(1);

        // back-pressure and overrun
        cont = 1'b1; sar_d = 8'h3C;
        pulse_start();
        tick(11);
        sar_d = 8'hC3;
        tick(11);
        cont = 1'b0;
        tick(12);
        clr_ovr = 1'b1; tick(1); clr_ovr = 1'b0; tick(2);
        res_ready = 1'b1; tick(1); res_ready = 1'b0;

        // simultaneous transfer and capture
        res_ready = 1'b1; cont = 1'b1;
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            sar_d = 8'($urandom);
            tick(1);
        end
        cont = 1'b0;
        tick(12);
        res_ready = 1'b0;

        // abort during the 4th bit-decision cycle
        pulse_start();
        tick(5);
        abort = 1'b1; tick(1); abort = 1'b0;
        tick(3);

        // asynchronous reset while sampling with a result pending
        sar_d = 8'h5A;
        pulse_start();
        tick(12);
        pulse_start();
        #2 rst = 1'b0;
        #10 rst = 1'b1;
        @(posedge clk); #1;
        sar_d = 8'h96;
        pulse_start();
        tick(14);

        // start held high, single-shot back-to-back
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            res_ready = 1'($urandom);
            sar_d     = 8'($urandom);
            tick(1);
        end
        start = 1'b0;
        tick(12);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            start     = ($urandom % 4) == 0;
            cont      = ($urandom % 3) == 0;
            abort     = ($urandom % 40) == 0;
            res_ready = 1'($urandom);
            clr_ovr   = ($urandom % 16) == 0;
            sar_d     = 8'($urandom);
            tick(1);
        end
        start = 1'b0; cont = 1'b0; abort = 1'b0; clr_ovr = 1'b0;
        res_ready = 1'b1;
        tick(15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
